// File: rtl/jk_pkg.sv
// jk_pkg: JK command encoding and the excitation function shared by the JK counter.
package jk_pkg;
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Returns {j,k} that moves a cell from q to n; never yields JK_TGL.
    function automatic logic [1:0] jk_excite(input logic q, input logic n);
        return {~q & n, q & ~n};
    endfunction
endpackage

// File: rtl/jk_cell.sv
// jk_cell: single JK flip-flop; 00 hold, 01 reset, 10 set, 11 toggle on the rising edge.
module jk_cell (
    input  logic clk,
    input  logic j,
    input  logic k,
    output logic q
);
    logic q_q;

    always_ff @(posedge clk) begin
        q_q <= (j & k) ? ~q_q : j ? 1'b1 : k ? 1'b0 : q_q;
    end

    assign q = q_q;
endmodule

// File: rtl/jk_counter.sv
// jk_counter: modulo-N up/down counter stored in a bank of JK cells driven by excitation logic.
// Optional JK_COUNTER_SATURATE_EN: stop at the bounds instead of wrapping (wrap tied low).
module jk_counter
    import jk_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MODULO = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);
    if (MODULO < 2 || MODULO > 2 ** WIDTH) begin : g_bad_modulo
        $error("jk_counter: MODULO out of range 2..2**WIDTH");
    end

`ifdef JK_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] q_q, n_d, up_nx, dn_nx, ld_val, j_vec, k_vec;
    logic             at_top, at_bot, oor, wrap_d, wrap_q;

    assign at_top = q_q == MAX;
    assign at_bot = q_q == '0;
    assign oor    = 32'(q_q) >= MODULO;
    assign ld_val = (32'(d) < MODULO) ? d : MAX;
    // Out-of-range states recover to the bound in the direction of travel.
    assign up_nx  = oor ? '0 : at_top ? (SAT ? MAX : '0) : q_q + WIDTH'(1);
    assign dn_nx  = oor ? MAX : at_bot ? (SAT ? '0 : MAX) : q_q - WIDTH'(1);
    assign n_d    = load ? ld_val : en ? (up ? up_nx : dn_nx) : q_q;
    assign tc     = en & ~load & (up ? at_top : at_bot);
    assign wrap_d = tc & ~SAT;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [1:0] jk;
        assign jk       = rst_n ? jk_excite(q_q[i], n_d[i]) : JK_RST;
        assign j_vec[i] = jk[1];
        assign k_vec[i] = jk[0];
        jk_cell u_cell (
            .clk (clk),
            .j   (jk[1]),
            .k   (jk[0]),
            .q   (q_q[i])
        );
    end

    always_ff @(posedge clk) begin
        wrap_q <= !rst_n ? 1'b0 : wrap_d;
    end

    assign q    = q_q;
    assign wrap = wrap_q;
endmodule

// File: tb/tb_jk_counter.sv
// tb_jk_counter: directed plus randomized checks of jk_counter against an arithmetic model.
// Honours JK_COUNTER_SATURATE_EN when the build defines it.
module tb_jk_counter;
    localparam int WIDTH  = 4;
    localparam int MODULO = 10;
`ifdef JK_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n, en, up, load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc, wrap;

    int  errors = 0;
    int  checks = 0;
    int  m_cnt  = 0;
    bit  m_wrap = 1'b0;
    bit  known  = 1'b0;

    jk_counter #(.WIDTH(WIDTH), .MODULO(MODULO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .up    (up),
        .load  (load),
        .d     (d),
        .q     (q),
        .tc    (tc),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit r, input bit e, input bit u, input bit l, input int dv);
        bit exp_tc;
        rst_n = r; en = e; up = u; load = l; d = WIDTH'(dv);
        #1;
        if (known) begin
            exp_tc = e && !l && (u ? m_cnt == MODULO - 1 : m_cnt == 0);
            check("q_pre", 32'(q), m_cnt);
            check("tc", 32'(tc), 32'(exp_tc));
            if (r) check("jk_no_toggle", 32'(dut.j_vec & dut.k_vec), 0);
            if (r && !l && !e) begin
                check("hold_j", 32'(dut.j_vec), 0);
                check("hold_k", 32'(dut.k_vec), 0);
            end
        end
        @(posedge clk);
        if (!r) begin
            m_cnt = 0; m_wrap = 0; known = 1;
        end else if (l) begin
            m_cnt = dv < MODULO ? dv : MODULO - 1; m_wrap = 0;
        end else if (e && u) begin
            m_wrap = !SAT && m_cnt == MODULO - 1;
            m_cnt  = m_cnt == MODULO - 1 ? (SAT ? m_cnt : 0) : m_cnt + 1;
        end else if (e) begin
            m_wrap = !SAT && m_cnt == 0;
            m_cnt  = m_cnt == 0 ? (SAT ? 0 : MODULO - 1) : m_cnt - 1;
        end else begin
            m_wrap = 0;
        end
        @(negedge clk);
        if (known) begin
            check("q", 32'(q), m_cnt);
            check("wrap", 32'(wrap), 32'(m_wrap));
        end
    endtask

    initial begin
        rst_n = 1; en = 0; up = 1; load = 0; d = '0;
        @(negedge clk);
        repeat (2) step(0, 1, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 1, 1, 6);
        step(1, 1, 0, 1, 13);
        step(1, 0, 1, 1, 7);
        for (int i = 0; i < 5; i++) step(1, 0, i % 2, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 1, 8);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) step(1, 1, 0, 0, 0);
        step(1, 0, 1, 1, 15);
        step(1, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 400; i++)
            step($urandom_range(19) != 0, $urandom_range(3) != 0, $urandom_range(1),
                 $urandom_range(7) == 0, $urandom_range(15));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
